// File: rtl/bin_mul_if.sv
// Operand/result bundle for the shift-add dividend reconstructor.
interface bin_mul_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH:0]       divisor;
    logic [WIDTH:0]       remainder;
    logic [2*WIDTH+1:0]   dividend;
    logic                 busy;
    logic                 done;
    logic                 ovf;
    logic                 rem_err;

    // Requester side: drives operands and start, observes result and flags.
    modport master (
        output start, quot, divisor, remainder,
        input  dividend, busy, done, ovf, rem_err
    );

    // Reconstructor side.
    modport slave (
        input  start, quot, divisor, remainder,
        output dividend, busy, done, ovf, rem_err
    );
endinterface

// File: rtl/bin_mul.sv
// Reconstructs dividend = quot*divisor + remainder with a serial
// LSB-first shift-add multiply (WIDTH edges) followed by one add edge.
module bin_mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    bin_mul_if.slave  bus
);
    localparam int unsigned DW = 2 * WIDTH + 2;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  quot_q;
    logic [WIDTH:0]    div_q;
    logic [WIDTH:0]    rem_q;
    logic [DW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic              last_bit_c;
    logic [DW-1:0]     sum_c;

    assign last_bit_c = (cnt_q == CW'(WIDTH - 1));
    assign sum_c      = acc_q + DW'(rem_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so it never queues.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = MUL;
            MUL:     if (last_bit_c) state_d = ADD;
            ADD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and shift-add accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= '0;
            div_q  <= '0;
            rem_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        quot_q <= bus.quot;
                        div_q  <= bus.divisor;
                        rem_q  <= bus.remainder;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                MUL: begin
                    if (quot_q[cnt_q]) begin
                        acc_q <= acc_q + (DW'(div_q) << cnt_q);
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status and result; result/flags only move on the add edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dividend <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.rem_err  <= 1'b0;
        end else begin
            bus.busy <= (state_d != IDLE);
            bus.done <= (state_q == ADD);
            if (state_q == ADD) begin
                bus.dividend <= sum_c;
                bus.ovf      <= |sum_c[DW-1:WIDTH];
                bus.rem_err  <= (rem_q >= div_q);
            end
        end
    end
endmodule
